muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, beside the ALU.
//  - Takes operands after the forwarding muxes (ALU input 1, forwarded rs2) on a one-cycle start.
//  - Stalls PC, IF/ID, ID/EX and EX/MEM while it runs.
//  - Drives its result into the EX/MEM ALU-result slot on the done cycle, in place of the ALU output.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit_div_step.sv | 34 +++
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   - M-extension funct3 codes and the funct7 value that selects them
//   - FSM state encoding
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Division ops all have funct3[2] set; remainder ops additionally funct3[1].
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step on unsigned magnitudes.
//   rem_in   partial remainder (always < divisor)
//   quo_in   dividend bits not yet consumed (MSB first) with quotient bits
//            shifted in from the bottom
//   divisor  unsigned divisor magnitude
//   rem_out  next partial remainder
//   quo_out  quo_in shifted left with the new quotient bit appended
module muldiv_unit_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // shifted < 2*divisor, so the top bit of the difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_out = diff[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
// One shift-add or restoring-subtract step per cycle; divide-by-zero and
// signed overflow finish in a single cycle.
// Ports:
//   clk, reset     clock; synchronous active-low reset
//   start, flush   op request / squash (flush wins)
//   funct3, rd_in  operation select and destination register
//   a, b           post-forwarding rs1 / rs2 operands
//   busy           RUN or DONE
//   stall          freeze upstream stages and EX/MEM load
//   done           one-cycle pulse, result/rd_out valid
//   result, rd_out final value and captured rd, held until the next result
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;    // multiplicand (MUL*) or divisor (DIV*/REM*)
    logic [2*XLEN-1:0] acc_q;     // {hi, lo}: product, or {remainder, quotient}

    // Request decode
    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg, in_div;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic            neg_in;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        accept   = (state_q == MD_IDLE) && start && !flush;
        in_div   = is_div_op(funct3);
        a_signed = (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
                   (funct3 == MD_DIV)  || (funct3 == MD_REM);
        b_signed = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
        a_neg    = a_signed && a[XLEN-1];
        b_neg    = b_signed && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = in_div && (b == '0);
        div_ovf  = in_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        fast     = div_zero || div_ovf;
        // Remainder follows the dividend sign; quotient/product follow the sign mismatch.
        neg_in   = (in_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        if (div_zero)
            fast_res = funct3[1] ? a : '1;
        else
            fast_res = funct3[1] ? '0 : a;
    end

    // Iteration step
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_rem, div_quo;
    logic [2*XLEN-1:0] step_next;
    logic [XLEN-1:0]   final_res;

    muldiv_unit_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc_q[2*XLEN-1:XLEN]),
        .quo_in  (acc_q[XLEN-1:0]),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    function automatic logic [XLEN-1:0] fix_result(input logic [2:0] op, input logic neg,
                                                   input logic [2*XLEN-1:0] acc);
        logic [XLEN-1:0]   part;
        logic [2*XLEN-1:0] full;
        part = '0;
        full = '0;
        if (is_div_op(op)) begin
            part = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
            return neg ? -part : part;
        end
        full = neg ? -acc : acc;
        return (op == MD_MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
    endfunction

    // Shift-add: low half starts as the multiplier and is consumed LSB first
    // while the partial product grows into the high half.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        step_next = is_div_op(op_q) ? {div_rem, div_quo} : mul_next;
        final_res = fix_result(op_q, neg_q, step_next);
    end

    // FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: if (accept) state_d = fast ? MD_DONE : MD_RUN;
            MD_RUN:  if (cnt_q == LAST_CNT) state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (flush) state_d = MD_IDLE;
    end

    always_comb begin
        busy  = (state_q == MD_RUN) || (state_q == MD_DONE);
        stall = accept || (state_q == MD_RUN);
        done  = (state_q == MD_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        op_q   <= funct3;
                        rd_q   <= rd_in;
                        neg_q  <= neg_in;
                        cnt_q  <= '0;
                        opnd_q <= in_div ? b_mag : a_mag;
                        acc_q  <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
                        if (fast) begin
                            result <= fast_res;
                            rd_out <= rd_in;
                        end
                    end
                end
                MD_RUN: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if ((cnt_q == LAST_CNT) && !flush) begin
                        result <= final_res;
                        rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .rd_in  (rd_in),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    // Issues one op and waits for done. Cycle 0 is the cycle start is presented;
    // lat is the cycle in which done is seen (101 on timeout).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] rd, output logic [31:0] res, output int lat,
                          output int stalls);
        @(posedge clk); #1;
        funct3 = f3; a = av; b = bv; rd_in = rd; start = 1'b1;
        #1;
        stalls = stall ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (lat = 1; lat <= 100; lat++) begin
            if (done) break;
            if (stall) stalls++;
            @(posedge clk); #1;
        end
        res = result;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rd_in = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, stall, done} !== 3'b000) begin
            $display("FAIL reset_ctrl busy/stall/done=%b required 000", {busy, stall, done});
            failures++;
        end
        checks++;
        if (result !== 32'h0 || rd_out !== 5'd0) begin
            $display("FAIL reset_data result=%h rd_out=%0d required 0/0", result, rd_out);
            failures++;
        end
        reset = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int lat, stalls;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3, res, lat, stalls);
        checks++;
        if (lat !== 33) begin $display("FAIL mul_latency got=%0d required 33", lat); failures++; end
        checks++;
        if (stalls !== 33) begin $display("FAIL mul_stall_cycles got=%0d required 33", stalls); failures++; end
        checks++;
        if (stall !== 1'b0) begin $display("FAIL mul_stall_done got=%b required 0", stall); failures++; end
        checks++;
        if (res !== 32'hFFFFFFEB) begin $display("FAIL mul_result got=%h required ffffffeb", res); failures++; end
        checks++;
        if (rd_out !== 5'd3) begin $display("FAIL mul_rd got=%0d required 3", rd_out); failures++; end
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin $display("FAIL mul_idle busy/done=%b required 00", {busy, done}); failures++; end
        run_op(3'b000, 32'd0, 32'd5, 5'd4, res, lat, stalls);
        checks++;
        if (res !== 32'h0 || lat !== 33) begin
            $display("FAIL mul_zero got=%h lat=%0d required 0 lat 33", res, lat); failures++;
        end
    endtask

    task automatic test_mulh();
        logic [31:0] res;
        int lat, stalls;
        run_op(3'b001, 32'h80000000, 32'h80000000, 5'd5, res, lat, stalls);
        checks++;
        if (res !== 32'h40000000) begin $display("FAIL mulh got=%h required 40000000", res); failures++; end
        run_op(3'b011, 32'h80000000, 32'h80000000, 5'd6, res, lat, stalls);
        checks++;
        if (res !== 32'h40000000) begin $display("FAIL mulhu got=%h required 40000000", res); failures++; end
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 5'd7, res, lat, stalls);
        checks++;
        if (res !== 32'hFFFFFFFF) begin $display("FAIL mulhsu got=%h required ffffffff", res); failures++; end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        int lat, stalls;
        run_op(3'b101, 32'h1234, 32'd0, 5'd8, res, lat, stalls);
        checks++;
        if (lat !== 1) begin $display("FAIL divu0_latency got=%0d required 1", lat); failures++; end
        checks++;
        if (res !== 32'hFFFFFFFF) begin $display("FAIL divu0 got=%h required ffffffff", res); failures++; end
        checks++;
        if (rd_out !== 5'd8) begin $display("FAIL divu0_rd got=%0d required 8", rd_out); failures++; end
        run_op(3'b111, 32'h1234, 32'd0, 5'd9, res, lat, stalls);
        checks++;
        if (res !== 32'h1234) begin $display("FAIL remu0 got=%h required 1234", res); failures++; end
        run_op(3'b110, 32'hFFFFFFFB, 32'd0, 5'd9, res, lat, stalls);
        checks++;
        if (res !== 32'hFFFFFFFB || lat !== 1) begin
            $display("FAIL rem0 got=%h lat=%0d required fffffffb lat 1", res, lat); failures++;
        end
    endtask

    task automatic test_div_signed();
        logic [31:0] res;
        int lat, stalls;
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, res, lat, stalls);
        checks++;
        if (res !== 32'h80000000 || lat !== 1) begin
            $display("FAIL div_ovf got=%h lat=%0d required 80000000 lat 1", res, lat); failures++;
        end
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, res, lat, stalls);
        checks++;
        if (res !== 32'h0 || lat !== 1) begin
            $display("FAIL rem_ovf got=%h lat=%0d required 0 lat 1", res, lat); failures++;
        end
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd12, res, lat, stalls);
        checks++;
        if (res !== 32'hFFFFFFFF || lat !== 33) begin
            $display("FAIL rem_neg got=%h lat=%0d required ffffffff lat 33", res, lat); failures++;
        end
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd13, res, lat, stalls);
        checks++;
        if (res !== 32'hFFFFFFFD) begin $display("FAIL div_neg got=%h required fffffffd", res); failures++; end
        run_op(3'b111, 32'd100, 32'd7, 5'd14, res, lat, stalls);
        checks++;
        if (res !== 32'd2) begin $display("FAIL remu got=%h required 2", res); failures++; end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, stalls, dones, cyc;
        // Previous op left result=2.
        @(posedge clk); #1;
        funct3 = 3'b100; a = 32'd1000; b = 32'd3; rd_in = 5'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (cyc = 1; cyc < 10; cyc++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        if (done) dones++;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dones !== 0) begin
            $display("FAIL flush_abort busy=%b done=%b dones=%0d required 0/0/0", busy, done, dones);
            failures++;
        end
        checks++;
        if (result !== 32'd2) begin $display("FAIL flush_result got=%h required 2", result); failures++; end
        run_op(3'b101, 32'd100, 32'd7, 5'd16, res, lat, stalls);
        checks++;
        if (res !== 32'd14) begin $display("FAIL after_flush got=%h required e", res); failures++; end
        // start and flush together: nothing accepted
        @(posedge clk); #1;
        funct3 = 3'b000; a = 32'd3; b = 32'd3; rd_in = 5'd20; start = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin $display("FAIL flush_start_stall got=%b required 0", stall); failures++; end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || rd_out !== 5'd16) begin
            $display("FAIL flush_start busy=%b rd_out=%0d required 0/16", busy, rd_out); failures++;
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        funct3 = 3'b000; a = 32'd7; b = 32'd3; rd_in = 5'd21; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, stall, done} !== 3'b000 || result !== 32'h0 || rd_out !== 5'd0) begin
            $display("FAIL reset_mid busy/stall/done=%b result=%h rd_out=%0d required 000/0/0",
                     {busy, stall, done}, result, rd_out);
            failures++;
        end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        int dones, cyc;
        @(posedge clk); #1;
        funct3 = 3'b000; a = 32'd3; b = 32'd4; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        rd_in = 5'd17;
        dones = 0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (done) begin
                dones++;
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1) begin $display("FAIL b2b_done_count got=%0d required 1", dones); failures++; end
        checks++;
        if (rd_out !== 5'd9 || result !== 32'd12) begin
            $display("FAIL b2b_capture rd_out=%0d result=%h required 9/c", rd_out, result); failures++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div_zero();
        test_div_signed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
